// File: rtl/test_harness_pkg.sv
// Shared definitions for the MMIO test harness: register offsets,
// result encodings, FSM state type and the STATUS word layout.
package test_harness_pkg;

    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_RESULT = 4'h8;
    localparam logic [3:0] OFF_CYCLES = 4'hC;

    localparam int unsigned STATUS_LVL_W = 9;

    typedef enum logic [1:0] {
        RES_RUNNING = 2'b00,
        RES_PASS    = 2'b01,
        RES_FAIL    = 2'b10,
        RES_UNKNOWN = 2'b11
    } result_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef struct packed {
        logic [16:0]             rsvd;
        logic                    timeout;
        logic [1:0]              result;
        logic                    ovf;
        logic                    full;
        logic                    empty;
        logic [STATUS_LVL_W-1:0] level;
    } status_t;

    // Map a value written to RESULT onto its latched result code.
    function automatic result_e result_code(input logic [31:0] value);
        if (value == 32'd1) begin
            return RES_PASS;
        end else if (value == 32'd0) begin
            return RES_FAIL;
        end
        return RES_UNKNOWN;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO with power-of-two depth; pushes into a full
// FIFO are dropped here, the caller decides how to flag them.
module byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               wdata,
    input  logic                     pop,
    output logic [7:0]               rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full,
    output logic                     empty_next_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok, pop_ok;

    // Next pointer and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        push_ok = push && (level_q != LVL_W'(DEPTH));
        pop_ok  = pop && (level_q != '0);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push_ok) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Pointer and level registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage array; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    assign rdata        = mem_q[rptr_q];
    assign level        = level_q;
    assign empty        = (level_q == '0);
    assign full         = (level_q == LVL_W'(DEPTH));
    assign empty_next_c = (level_d == '0);

endmodule

// File: rtl/test_harness_mmio.sv
// MMIO test harness: console TX FIFO, result/halt driven end-of-test FSM,
// cycle counter. Optional watchdog enabled by TEST_HARNESS_WATCHDOG_EN.
module test_harness_mmio
    import test_harness_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned MAX_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_enable,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    input  logic        cpu_halted,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        test_done,
    output logic [1:0]  test_result,
    output logic        timeout
);

    localparam int unsigned LVL_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] WD_LIMIT = 32'(MAX_CYCLES - 1);
`ifdef TEST_HARNESS_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic             hit_c, wr_c, rd_c, push_c, pop_c, result_wr_c;
    logic [3:0]       off_c;
    logic             fifo_empty, fifo_full, fifo_empty_next_c;
    logic [LVL_W-1:0] fifo_level;
    logic [7:0]       fifo_rdata;
    status_t          status_c;

    state_e      state_q, state_d;
    result_e     code_q, code_d;
    logic        ovf_q, ovf_d;
    logic        timeout_q, timeout_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] cycles_q, cycles_d;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (push_c),
        .wdata        (mem_wdata[7:0]),
        .pop          (pop_c),
        .rdata        (fifo_rdata),
        .level        (fifo_level),
        .empty        (fifo_empty),
        .full         (fifo_full),
        .empty_next_c (fifo_empty_next_c)
    );

    // Address decode and console handshake.
    always_comb begin
        hit_c       = mem_enable && (mem_addr[31:4] == BASE_ADDR[31:4]);
        wr_c        = hit_c && mem_write;
        rd_c        = hit_c && mem_read && !mem_write;
        off_c       = mem_addr[3:0];
        push_c      = wr_c && (off_c == OFF_TXDATA);
        result_wr_c = wr_c && (off_c == OFF_RESULT);
        pop_c       = !fifo_empty && tx_ready;
    end

    // STATUS word assembled from live state.
    always_comb begin
        status_c         = '0;
        status_c.level   = STATUS_LVL_W'(fifo_level);
        status_c.empty   = fifo_empty;
        status_c.full    = fifo_full;
        status_c.ovf     = ovf_q;
        status_c.result  = test_result;
        status_c.timeout = timeout_q;
    end

    // Bus response, overflow flag, end-of-test FSM and cycle counter.
    always_comb begin
        ready_d   = hit_c;
        rdata_d   = '0;
        ovf_d     = ovf_q || (push_c && fifo_full);
        state_d   = state_q;
        code_d    = code_q;
        timeout_d = timeout_q;
        cycles_d  = cycles_q;

        if (rd_c) begin
            unique case (off_c)
                OFF_STATUS: rdata_d = status_c;
                OFF_CYCLES: rdata_d = cycles_q;
                default:    rdata_d = '0;
            endcase
        end

        // Enter DONE directly when nothing is left to drain.
        unique case (state_q)
            ST_RUN: begin
                if (result_wr_c) begin
                    code_d  = result_code(mem_wdata);
                    state_d = fifo_empty_next_c ? ST_DONE : ST_DRAIN;
                end else if (cpu_halted) begin
                    code_d  = RES_UNKNOWN;
                    state_d = fifo_empty_next_c ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty_next_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (WD_EN && (state_q != ST_DONE) && (cycles_q == WD_LIMIT)) begin
            state_d   = ST_DONE;
            code_d    = RES_FAIL;
            timeout_d = 1'b1;
        end

        // Count while the test is live; freeze on the step into DONE.
        if ((state_q != ST_DONE) && (state_d != ST_DONE) && (cycles_q != 32'hFFFF_FFFF)) begin
            cycles_d = cycles_q + 32'd1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            code_q    <= RES_RUNNING;
            ovf_q     <= 1'b0;
            timeout_q <= 1'b0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            ovf_q     <= ovf_d;
            timeout_q <= timeout_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            cycles_q  <= cycles_d;
        end
    end

    assign mem_ready   = ready_q;
    assign mem_rdata   = rdata_q;
    assign tx_valid    = !fifo_empty;
    assign tx_data     = fifo_rdata;
    assign test_done   = (state_q == ST_DONE);
    assign test_result = test_done ? code_q : RES_RUNNING;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_test_harness_mmio.sv
// Bench for test_harness_mmio: directed scenarios with literal expectations
// followed by random traffic checked every cycle against a queue-based model.
module tb_test_harness_mmio;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int unsigned DEPTH = 16;
`ifdef TEST_HARNESS_WATCHDOG_EN
    localparam bit          WD   = 1'b1;
    localparam int unsigned MAXC = 100;
`else
    localparam bit          WD   = 1'b0;
    localparam int unsigned MAXC = 50000;
`endif

    logic        clk = 1'b0;
    logic        rst, mem_enable, mem_read, mem_write, cpu_halted, tx_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready, tx_valid, test_done, timeout;
    logic [7:0]  tx_data;
    logic [1:0]  test_result;

    always #5 clk = ~clk;

    test_harness_mmio #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH),
        .MAX_CYCLES (MAXC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_enable  (mem_enable),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .cpu_halted  (cpu_halted),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .test_done   (test_done),
        .test_result (test_result),
        .timeout     (timeout)
    );

    int tests = 0;
    int fails = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, want, $time);
        end
    endfunction

    // Behavioural model: byte queue, "a verdict has been latched" flag,
    // "test finished" flag, and the observable registers.
    logic [7:0]  q[$];
    bit          m_valid = 1'b0;
    bit          m_ovf, m_trig, m_done, m_to, m_ready;
    logic [1:0]  m_code;
    logic [31:0] m_cycles, m_rdata;

    always @(posedge clk) begin : model_step
        bit hit, wr, rd, pre_done, will_pop, room;
        if (rst) begin
            q.delete();
            m_ovf = 0; m_trig = 0; m_done = 0; m_to = 0; m_ready = 0;
            m_code = 2'b00; m_cycles = 0; m_rdata = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            hit      = mem_enable && (mem_addr[31:4] == BASE[31:4]);
            wr       = hit && mem_write;
            rd       = hit && mem_read && !mem_write;
            pre_done = m_done;
            m_ready  = hit;
            m_rdata  = 0;
            if (rd && mem_addr[3:0] == 4'h4)
                m_rdata = {17'b0, m_to, (m_done ? m_code : 2'b00), m_ovf,
                           q.size() == DEPTH, q.size() == 0, 9'(q.size())};
            if (rd && mem_addr[3:0] == 4'hC)
                m_rdata = m_cycles;
            will_pop = (q.size() != 0) && tx_ready;
            room     = q.size() < DEPTH;
            if (will_pop) void'(q.pop_front());
            if (wr && mem_addr[3:0] == 4'h0) begin
                if (room) q.push_back(mem_wdata[7:0]);
                else m_ovf = 1;
            end
            if (!m_trig && wr && mem_addr[3:0] == 4'h8) begin
                m_trig = 1;
                m_code = (mem_wdata == 1) ? 2'b01 : (mem_wdata == 0) ? 2'b10 : 2'b11;
            end else if (!m_trig && cpu_halted) begin
                m_trig = 1;
                m_code = 2'b11;
            end
            if (m_trig && q.size() == 0) m_done = 1;
            if (WD && !pre_done && m_cycles == 32'(MAXC - 1)) begin
                m_done = 1; m_to = 1; m_code = 2'b10; m_trig = 1;
            end
            if (!pre_done && !m_done && m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("tx_valid", tx_valid, 32'(q.size() != 0));
            if (q.size() != 0) chk("tx_data", tx_data, q[0]);
            chk("test_done", test_done, 32'(m_done));
            chk("test_result", test_result, m_done ? m_code : 2'b00);
            chk("timeout", timeout, 32'(m_to));
            chk("mem_ready", mem_ready, 32'(m_ready));
            chk("mem_rdata", mem_rdata, m_rdata);
        end
    end

    task automatic cyc(input bit en, input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data);
        mem_enable = en; mem_read = rd; mem_write = wr; mem_addr = addr; mem_wdata = data;
        @(negedge clk);
    endtask

    task automatic wr32(input logic [31:0] addr, input logic [31:0] data);
        cyc(1'b1, 1'b0, 1'b1, addr, data);
    endtask

    task automatic rd32(input logic [31:0] addr);
        cyc(1'b1, 1'b1, 1'b0, addr, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
    endtask

    logic [3:0] offs [4] = '{4'h0, 4'h4, 4'h8, 4'hC};

    initial begin
        int bias;
        logic [3:0]  off;
        logic [31:0] addr, data;
        bit en, rd, wr;

        rst = 1'b1; mem_enable = 0; mem_read = 0; mem_write = 0;
        mem_addr = 0; mem_wdata = 0; cpu_halted = 0; tx_ready = 0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_test_done", test_done, 0);
        chk("rst_result", test_result, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_ready", mem_ready, 0);
        chk("rst_rdata", mem_rdata, 0);

        // Two console bytes stream straight through.
        tx_ready = 1'b1;
        wr32(BASE, 32'h48);
        chk("hi_valid0", tx_valid, 1);
        chk("hi_data0", tx_data, 32'h48);
        wr32(BASE, 32'h69);
        chk("hi_valid1", tx_valid, 1);
        chk("hi_data1", tx_data, 32'h69);
        idle(1);
        chk("hi_valid2", tx_valid, 0);

        // Overfill with the consumer stalled.
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) wr32(BASE, 32'(i));
        rd32(BASE + 32'h4);
        chk("ovf_ready", mem_ready, 1);
        chk("ovf_status", mem_rdata, 32'h0000_0C10);
        rd32(BASE);
        chk("wo_read_ready", mem_ready, 1);
        chk("wo_read_data", mem_rdata, 0);
        wr32(BASE + 32'h4, 32'hFFFF_FFFF);
        rd32(BASE + 32'h4);
        chk("ro_write_noeffect", mem_rdata, 32'h0000_0C10);
        rd32(BASE + 32'hC);
        chk("cycles_value", mem_rdata, 32'd21);
        cyc(1'b1, 1'b1, 1'b0, BASE + 32'h10, 32'h0);
        chk("miss_ready", mem_ready, 0);

        // Pass verdict with three bytes queued.
        do_reset();
        for (int i = 0; i < 3; i++) wr32(BASE, 32'h41 + 32'(i));
        tx_ready = 1'b1;
        wr32(BASE + 32'h8, 32'd1);
        chk("drain_done1", test_done, 0);
        chk("drain_result1", test_result, 0);
        idle(1);
        chk("drain_done2", test_done, 0);
        idle(1);
        chk("drain_done3", test_done, 1);
        chk("drain_result3", test_result, 2'b01);

        // Halt without verdict, later RESULT ignored.
        do_reset();
        cpu_halted = 1'b1;
        idle(1);
        cpu_halted = 1'b0;
        chk("halt_done", test_done, 1);
        chk("halt_result", test_result, 2'b11);
        wr32(BASE + 32'h8, 32'd1);
        chk("halt_result_sticky", test_result, 2'b11);

        // RESULT write beats a simultaneous halt.
        do_reset();
        cpu_halted = 1'b1;
        wr32(BASE + 32'h8, 32'd0);
        cpu_halted = 1'b0;
        chk("prec_result", test_result, 2'b10);

        // Reset in the middle of draining.
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr32(BASE, 32'(i));
        wr32(BASE + 32'h8, 32'd7);
        chk("mid_drain_valid", tx_valid, 1);
        chk("mid_drain_done", test_done, 0);
        do_reset();
        chk("post_rst_valid", tx_valid, 0);
        chk("post_rst_done", test_done, 0);

`ifdef TEST_HARNESS_WATCHDOG_EN
        do_reset();
        idle(99);
        chk("wd_not_yet", test_done, 0);
        idle(1);
        chk("wd_done", test_done, 1);
        chk("wd_timeout", timeout, 1);
        chk("wd_result", test_result, 2'b10);
        rd32(BASE + 32'hC);
        chk("wd_cycles", mem_rdata, 32'd99);
`else
        do_reset();
        idle(120);
        chk("nowd_timeout", timeout, 0);
        chk("nowd_done", test_done, 0);
`endif

        // Random traffic against the model.
        bias = 2;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) bias = $urandom_range(0, 4);
            rst        = ($urandom_range(0, 149) == 0);
            tx_ready   = ($urandom_range(0, 3) < bias);
            cpu_halted = ($urandom_range(0, 199) == 0);
            en  = $urandom_range(0, 1) != 0;
            off = offs[$urandom_range(0, 3)];
            wr  = $urandom_range(0, 1) != 0;
            rd  = !wr && ($urandom_range(0, 7) != 0);
            if (wr && off == 4'h8 && $urandom_range(0, 7) != 0) off = 4'h0;
            case ($urandom_range(0, 9))
                9:       addr = $urandom;
                8:       addr = BASE + 32'($urandom_range(0, 15));
                default: addr = BASE + 32'(off);
            endcase
            data = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 2));
            cyc(en, rd, wr, addr, data);
        end
        rst = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/test_harness_mmio.md
TEST_HARNESS_MMIO -- requirements
Module: test_harness_mmio

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1000_0000, base of the 16-byte register window.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, power of two from 2 to 256, console TX FIFO entries.
REQ-003 SHALL have parameter MAX_CYCLES, default 50000, watchdog limit in clk cycles.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port mem_enable, input, 1 bit: bus access strobe.
REQ-007 SHALL have port mem_read, input, 1 bit: read qualifier.
REQ-008 SHALL have port mem_write, input, 1 bit: write qualifier.
REQ-009 SHALL have port mem_addr, input, 32 bits: byte address.
REQ-010 SHALL have port mem_wdata, input, 32 bits: write data.
REQ-011 SHALL have port mem_rdata, output, 32 bits: registered read data.
REQ-012 SHALL have port mem_ready, output, 1 bit: access-complete pulse.
REQ-013 SHALL have port cpu_halted, input, 1 bit: processor halt indication.
REQ-014 SHALL have ports tx_valid (output, 1 bit), tx_data (output, 8 bits) and tx_ready (input, 1 bit): the console byte stream.
REQ-015 SHALL have port test_done, output, 1 bit: test has ended.
REQ-016 SHALL have port test_result, output, 2 bits: 00 running, 01 pass, 10 fail, 11 unknown.
REQ-017 SHALL have port timeout, output, 1 bit: the watchdog ended the test.

Function
REQ-018 SHALL decode an access as hit when mem_enable is high and mem_addr[31:4] equals BASE_ADDR[31:4].
REQ-019 SHALL assert mem_ready exactly one cycle after a hit; mem_rdata SHALL be valid in that same cycle and zero otherwise.
REQ-020 SHALL implement the register map: 0x0 TXDATA (W), 0x4 STATUS (R), 0x8 RESULT (W), 0xC CYCLES (R); a write to a read-only register or a read of a write-only register SHALL complete with zero data and no side effect.
REQ-021 SHALL push mem_wdata[7:0] into the FIFO on a TXDATA write when the FIFO is not full; when full, the byte SHALL be dropped and the sticky bit ovf set.
REQ-022 SHALL return STATUS as: [8:0] level, [9] empty, [10] full, [11] ovf, [13:12] test_result, [14] timeout, and zero elsewhere.
REQ-023 SHALL drive tx_valid whenever the FIFO is non-empty, with tx_data equal to the head entry; a pop SHALL occur on tx_valid && tx_ready.
REQ-024 SHALL handle a push and a pop in the same cycle as follows: both take effect, the level is unchanged, and a push when full is still dropped even if a pop occurs in that cycle.
REQ-025 SHALL wrap the FIFO pointers modulo FIFO_DEPTH.
REQ-026 SHALL keep a 32-bit CYCLES counter that increments each cycle in RUN and DRAIN, freezes in DONE, and saturates at 32'hFFFF_FFFF.
REQ-027 SHALL implement the FSM states RUN, DRAIN and DONE.
REQ-028 SHALL leave RUN for DRAIN on a RESULT write, latching code 01 for value 1, 10 for value 0, and 11 for any other value.
REQ-029 SHALL leave RUN for DRAIN on cpu_halted with no prior RESULT write, latching code 11.
REQ-030 SHALL give a RESULT write precedence over cpu_halted when both occur in the same cycle.
REQ-031 SHALL ignore further RESULT writes while in DRAIN or DONE.
REQ-032 SHALL move from DRAIN to DONE in the first cycle the FIFO is empty; TXDATA writes in DRAIN SHALL still be accepted.
REQ-033 SHALL assert test_done only in DONE and drive test_result 00 until DONE is entered.

Reset
REQ-034 SHALL, on rst high at a rising edge, set: state RUN, FIFO empty, ovf 0, CYCLES 0, latched code 00, timeout 0, mem_ready 0, mem_rdata 0, tx_valid 0, test_done 0.
REQ-035 SHALL let rst asserted mid-DRAIN discard the FIFO contents with no further tx_valid.

Configuration
REQ-036 SHALL, with TEST_HARNESS_WATCHDOG_EN defined, go to DONE from RUN or DRAIN when CYCLES reaches MAX_CYCLES-1, setting timeout=1 and code 10 (fail), with precedence over a same-cycle RESULT write or halt.
REQ-037 SHALL, without TEST_HARNESS_WATCHDOG_EN, hold timeout at 0 and never time out.

Structure
REQ-038 SHALL place the register offsets, the result encodings and the FSM state type in package test_harness_pkg.
REQ-039 SHALL implement the FIFO as the sub-module byte_fifo, parameterised by DEPTH.

Verification
REQ-040 SHALL cover: TXDATA writes of 0x48 then 0x69 with tx_ready=1 -> tx_data 0x48 then 0x69, each with tx_valid for one cycle.
REQ-041 SHALL cover: tx_ready=0 and 17 writes at depth 16 -> STATUS reads 0x0000_0C10 (full, ovf, level 16).
REQ-042 SHALL cover: RESULT write of 1 with 3 bytes queued and tx_ready=1 -> test_done rises 3 cycles later with test_result=01.
REQ-043 SHALL cover: cpu_halted=1 with no RESULT write and an empty FIFO -> test_done next cycle with test_result=11.
REQ-044 SHALL cover: TEST_HARNESS_WATCHDOG_EN defined, MAX_CYCLES=100, no activity -> test_done and timeout at cycle 100, CYCLES read returns 99.
REQ-045 SHALL cover: rst asserted while in DRAIN with 5 bytes queued -> tx_valid 0 and test_done 0 on the following cycle.
